// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-WB instruction bundle and WB result/bypass signals
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_exc;
  logic        mem_reg_we;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_res;
  logic [31:0] mem_load_raw;
  logic [31:0] mem_pc4;
  logic [31:0] mem_csr_rdata;
  logic        rf_we;
  logic [4:0]  rf_wR;
  logic [31:0] rf_wD;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        retire;

  modport master (
    output mem_valid, mem_exc, mem_reg_we, mem_rd, mem_wb_sel, mem_funct3,
           mem_alu_res, mem_load_raw, mem_pc4, mem_csr_rdata,
    input  rf_we, rf_wR, rf_wD, fwd_valid, fwd_rd, fwd_data, retire
  );

  modport slave (
    input  mem_valid, mem_exc, mem_reg_we, mem_rd, mem_wb_sel, mem_funct3,
           mem_alu_res, mem_load_raw, mem_pc4, mem_csr_rdata,
    output rf_we, rf_wR, rf_wD, fwd_valid, fwd_rd, fwd_data, retire
  );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage: MEM/WB register, result mux, bypass, retire
// Optional 64-bit retired-instruction counter enabled by WB_INSTRET_EN.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  wb_stage_if.slave   wb
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  logic        valid_q;
  logic        exc_q;
  logic        reg_we_q;
  logic [4:0]  rd_q;
  logic [1:0]  wb_sel_q;
  logic [2:0]  funct3_q;
  logic [31:0] alu_res_q;
  logic [31:0] load_raw_q;
  logic [31:0] pc4_q;
  logic [31:0] csr_rdata_q;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] wd;
  logic        write_ok;
  logic        retire_int;

  // A flush only needs to clear valid; the payload fields are don't-care in a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      exc_q       <= 1'b0;
      reg_we_q    <= 1'b0;
      rd_q        <= 5'd0;
      wb_sel_q    <= 2'd0;
      funct3_q    <= 3'd0;
      alu_res_q   <= 32'd0;
      load_raw_q  <= 32'd0;
      pc4_q       <= 32'd0;
      csr_rdata_q <= 32'd0;
    end else if (!stall) begin
      if (flush) begin
        valid_q <= 1'b0;
      end else begin
        valid_q     <= wb.mem_valid;
        exc_q       <= wb.mem_exc;
        reg_we_q    <= wb.mem_reg_we;
        rd_q        <= wb.mem_rd;
        wb_sel_q    <= wb.mem_wb_sel;
        funct3_q    <= wb.mem_funct3;
        alu_res_q   <= wb.mem_alu_res;
        load_raw_q  <= wb.mem_load_raw;
        pc4_q       <= wb.mem_pc4;
        csr_rdata_q <= wb.mem_csr_rdata;
      end
    end
  end

  always_comb begin
    ld_byte = load_raw_q[7:0];
    case (alu_res_q[1:0])
      2'd0:    ld_byte = load_raw_q[7:0];
      2'd1:    ld_byte = load_raw_q[15:8];
      2'd2:    ld_byte = load_raw_q[23:16];
      default: ld_byte = load_raw_q[31:24];
    endcase
    // Halfword misalignment traps upstream, so offset bit 0 is ignored here.
    ld_half = alu_res_q[1] ? load_raw_q[31:16] : load_raw_q[15:0];
  end

  always_comb begin
    load_val = load_raw_q;
    case (funct3_q)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_val = {24'd0, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_val = {16'd0, ld_half};
      default: load_val = load_raw_q;
    endcase
  end

  always_comb begin
    wd = alu_res_q;
    case (wb_sel_q)
      2'b00:   wd = alu_res_q;
      2'b01:   wd = load_val;
      2'b10:   wd = pc4_q;
      default: wd = csr_rdata_q;
    endcase
  end

  assign write_ok   = valid_q & ~exc_q & reg_we_q & (rd_q != 5'd0);
  assign retire_int = valid_q & ~exc_q & ~stall;

  assign wb.rf_we     = write_ok & ~stall;
  assign wb.rf_wR     = rd_q;
  assign wb.rf_wD     = wd;
  // Bypass stays live while stalled so ID keeps seeing the held result.
  assign wb.fwd_valid = write_ok;
  assign wb.fwd_rd    = rd_q;
  assign wb.fwd_data  = wd;
  assign wb.retire    = retire_int;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= 64'd0;
    end else if (retire_int) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with randomized and directed stimulus
module tb_wb_stage;

  logic clk;
  logic rst_n;
  logic stall;
  logic flush;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  wb_stage_if wbi ();

  wb_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .wb    (wbi)
`ifdef WB_INSTRET_EN
    ,
    .instret (instret)
`endif
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  int errors = 0;
  int checks = 0;
  bit done = 0;

  // Reference view of the instruction sitting in WB.
  logic        s_valid = 0;
  logic        s_exc = 0;
  logic        s_wok = 0;
  logic [4:0]  s_rd = 0;
  logic [31:0] s_data = 0;
  logic [63:0] exp_cnt = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_wd(input logic [1:0] sel, input logic [2:0] f3,
                                         input logic [31:0] alu, input logic [31:0] raw,
                                         input logic [31:0] pc4, input logic [31:0] csr);
    logic [31:0] v;
    int off;
    off = int'(alu % 4);
    if (sel == 2'd0) return alu;
    if (sel == 2'd2) return pc4;
    if (sel == 2'd3) return csr;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (raw >> (8 * off)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (off >= 2) ? (raw >> 16) : (raw & 32'hFFFF);
      if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
      return v;
    end
    return raw;
  endfunction

  task automatic drive(input logic st, input logic fl, input logic v, input logic ex,
                       input logic we, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] raw,
                       input logic [31:0] pc4, input logic [31:0] csr);
    stall = st;
    flush = fl;
    wbi.mem_valid = v;
    wbi.mem_exc = ex;
    wbi.mem_reg_we = we;
    wbi.mem_rd = rd;
    wbi.mem_wb_sel = sel;
    wbi.mem_funct3 = f3;
    wbi.mem_alu_res = alu;
    wbi.mem_load_raw = raw;
    wbi.mem_pc4 = pc4;
    wbi.mem_csr_rdata = csr;
    #2;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Applies the edge to the reference model using the inputs the bench drove.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      s_valid = 0;
      s_wok = 0;
      sbq.delete();
      exp_cnt = 0;
    end else if (!stall) begin
      if (flush) begin
        s_valid = 0;
        s_wok = 0;
      end else begin
        s_valid = wbi.mem_valid;
        s_exc = wbi.mem_exc;
        s_rd = wbi.mem_rd;
        s_wok = wbi.mem_valid && !wbi.mem_exc && wbi.mem_reg_we && (wbi.mem_rd != 0);
        s_data = ref_wd(wbi.mem_wb_sel, wbi.mem_funct3, wbi.mem_alu_res,
                        wbi.mem_load_raw, wbi.mem_pc4, wbi.mem_csr_rdata);
        if (s_valid && !s_exc) sbq.push_back('{s_wok, s_rd, s_data});
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic exp_ret;
    if (rst_n && !done) begin
      exp_ret = s_valid && !s_exc && !stall;
      chk("retire", wbi.retire, exp_ret);
      chk("fwd_valid", wbi.fwd_valid, s_wok);
      if (s_wok) begin
        chk("fwd_rd", wbi.fwd_rd, s_rd);
        chk("fwd_data", wbi.fwd_data, s_data);
      end
      if (wbi.retire) begin
        if (sbq.size() == 0) begin
          chk("retire_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_rf_we", wbi.rf_we, e.we);
          if (e.we) begin
            chk("sb_rf_wR", wbi.rf_wR, e.rd);
            chk("sb_rf_wD", wbi.rf_wD, e.data);
          end
        end
      end else begin
        chk("rf_we_idle", wbi.rf_we, 0);
      end
`ifdef WB_INSTRET_EN
      chk("instret", instret, exp_cnt);
      if (exp_ret) exp_cnt = exp_cnt + 64'd1;
`endif
    end
  end

  initial begin
    logic [2:0] f3s[5];
    logic [1:0] offs[5];
    logic [31:0] ld_exp[5];
    f3s    = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    offs   = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
    ld_exp = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

    rst_n = 0;
    stall = 0;
    flush = 0;
    wbi.mem_valid = 0; wbi.mem_exc = 0; wbi.mem_reg_we = 0; wbi.mem_rd = 0;
    wbi.mem_wb_sel = 0; wbi.mem_funct3 = 0; wbi.mem_alu_res = 0; wbi.mem_load_raw = 0;
    wbi.mem_pc4 = 0; wbi.mem_csr_rdata = 0;
    #1;
    chk("reset_rf_we", wbi.rf_we, 0);
    chk("reset_retire", wbi.retire, 0);
    chk("reset_fwd_valid", wbi.fwd_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    bubble();
    tick();

    // ALU writeback
    drive(0, 0, 1, 0, 1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'd0, 32'd0, 32'd0);
    chk("alu_pre_we", wbi.rf_we, 0);
    tick();
    bubble();
    chk("alu_we", wbi.rf_we, 1);
    chk("alu_wR", wbi.rf_wR, 5);
    chk("alu_wD", wbi.rf_wD, 32'h1234_5678);
    chk("alu_retire", wbi.retire, 1);
    tick();

    // Load extraction
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, 1, 5'd10, 2'd1, f3s[i], {30'h100, offs[i]}, 32'h80FF_7F01,
            32'd0, 32'd0);
      tick();
      bubble();
      chk($sformatf("load%0d_wD", i), wbi.rf_wD, ld_exp[i]);
      tick();
    end

    // Stall holds the instruction; flush under stall is ignored
    drive(0, 0, 1, 0, 1, 5'd7, 2'd0, 3'd0, 32'hAAAA_0007, 32'd0, 32'd0, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, (i == 3), 1, 0, 1, 5'd9, 2'd0, 3'd0, 32'h9999_9999, 32'd0, 32'd0, 32'd0);
      chk("stall_we", wbi.rf_we, 0);
      chk("stall_retire", wbi.retire, 0);
      chk("stall_fwd_valid", wbi.fwd_valid, 1);
      chk("stall_fwd_rd", wbi.fwd_rd, 7);
      tick();
    end
    bubble();
    chk("unstall_we", wbi.rf_we, 1);
    chk("unstall_wR", wbi.rf_wR, 7);
    chk("unstall_retire", wbi.retire, 1);
    tick();
    bubble();
    chk("post_unstall_retire", wbi.retire, 0);
    tick();

    // Exception and rd=0 suppression
    drive(0, 0, 1, 1, 1, 5'd3, 2'd0, 3'd0, 32'h3333_3333, 32'd0, 32'd0, 32'd0);
    tick();
    bubble();
    chk("exc_we", wbi.rf_we, 0);
    chk("exc_fwd_valid", wbi.fwd_valid, 0);
    chk("exc_retire", wbi.retire, 0);
    tick();
    drive(0, 0, 1, 0, 1, 5'd0, 2'd2, 3'd0, 32'd0, 32'd0, 32'h0000_1004, 32'd0);
    tick();
    bubble();
    chk("rd0_we", wbi.rf_we, 0);
    chk("rd0_retire", wbi.retire, 1);
    tick();

    // Flush inserts a bubble
    drive(0, 1, 1, 0, 1, 5'd4, 2'd0, 3'd0, 32'h4444_4444, 32'd0, 32'd0, 32'd0);
    tick();
    bubble();
    chk("flush_retire", wbi.retire, 0);
    chk("flush_we", wbi.rf_we, 0);
    tick();

    // Reset mid-stall discards the held instruction
    drive(0, 0, 1, 0, 1, 5'd6, 2'd0, 3'd0, 32'h6666_6666, 32'd0, 32'd0, 32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    rst_n = 0;
    #1;
    chk("rst_rf_we", wbi.rf_we, 0);
    chk("rst_rf_wR", wbi.rf_wR, 0);
    chk("rst_rf_wD", wbi.rf_wD, 0);
    chk("rst_fwd_valid", wbi.fwd_valid, 0);
    chk("rst_fwd_rd", wbi.fwd_rd, 0);
    chk("rst_fwd_data", wbi.fwd_data, 0);
    chk("rst_retire", wbi.retire, 0);
`ifdef WB_INSTRET_EN
    chk("rst_instret", instret, 0);
`endif
    tick();
    rst_n = 1;
    bubble();
    chk("post_rst_retire", wbi.retire, 0);
    chk("post_rst_we", wbi.rf_we, 0);
    tick();

`ifdef WB_INSTRET_EN
    drive(0, 0, 1, 0, 1, 5'd8, 2'd0, 3'd0, 32'h8888_8888, 32'd0, 32'd0, 32'd0);
    tick();
    bubble();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    tick();
    chk("instret_wrap", instret, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 5) != 0,
            ($urandom % 10) == 0, ($urandom % 4) != 0,
            (($urandom % 8) == 0) ? 5'd0 : 5'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom, $urandom);
      tick();
    end

    bubble();
    tick();
    bubble();
    tick();
    chk("drain_empty", sbq.size(), 0);

    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
